// File: rtl/neq_b_b_b.sv
// Single-bit inequality primitive: y = a XOR b.
// Clock and reset exist only so all operator primitives share one port shape.
module neq_b_b_b (
    input  logic clock,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic y
);

    // Clock and reset are folded into a sink so lint sees them consumed;
    // synthesis drops this net because nothing reads it.
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset};

    assign y = a ^ b;

endmodule

// File: tb/tb_neq_b_b_b.sv
// Self-checking bench for neq_b_b_b: directed plan steps plus randomized
// operand/reset sequences compared against an arithmetic reference.
module tb_neq_b_b_b;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic y;

    int tests_run = 0;
    int tests_failed = 0;

    neq_b_b_b dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    always #5 clock = ~clock;

    // Reference: operands differ exactly when their sum is odd.
    function automatic logic ref_neq(input logic ra, input logic rb);
        int sum;
        sum = int'(ra) + int'(rb);
        return (sum % 2 == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed y=%b expected y=%b (a=%b b=%b reset=%b)",
                   tag, observed, expected, a, b, reset);
        end
    endtask

    // Update inputs just after a rising edge, as a registered producer would.
    task automatic drive(input logic na, input logic nb);
        @(posedge clock);
        #1;
        a = na;
        b = nb;
    endtask

    initial begin
        // Reset held for several cycles with zero operands.
        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_release_00", y, 1'b0);

        drive(1'b1, 1'b0);
        @(negedge clock);
        check("seq_10", y, 1'b1);
        drive(1'b0, 1'b1);
        @(negedge clock);
        check("seq_01", y, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clock);
        check("seq_11", y, 1'b0);

        // Full truth table with reset held high.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i[1], i[0]);
            @(negedge clock);
            check($sformatf("reset_high_%0d", i), y, ref_neq(i[1], i[0]));
        end
        reset = 1'b0;

        // Constant operands across a reset pulse: y must not move on any edge.
        drive(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            reset = (c == 3 || c == 4);
            check($sformatf("hold_post_%0d", c), y, 1'b1);
            @(negedge clock);
            check($sformatf("hold_neg_%0d", c), y, 1'b1);
        end
        reset = 1'b0;

        // Reset edges in isolation, between clock edges.
        a = 1'b0;
        b = 1'b1;
        #2 reset = 1'b1;
        #1 check("reset_rise_mid", y, 1'b1);
        #1 reset = 1'b0;
        #1 check("reset_fall_mid", y, 1'b1);

        // Zero-latency check without waiting for any clock edge.
        a = 1'b1;
        b = 1'b1;
        #1 check("comb_11", y, 1'b0);
        b = 1'b0;
        #1 check("comb_10", y, 1'b1);

        // Unknown operand propagates as unknown.
        a = 1'bx;
        b = 1'b0;
        #1 check("x_prop", y, 1'bx);
        a = 1'b0;

        // Randomized operands and reset.
        for (int r = 0; r < 64; r++) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            drive(ra, rb);
            reset = 1'($urandom_range(0, 1));
            @(negedge clock);
            check($sformatf("rand_%0d", r), y, ref_neq(ra, rb));
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, required completion before 100000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
